// File: rtl/mmc3_a12_scanline_filter_pkg.sv
// mmc3_pkg
// Shared types and default parameter values for the MMC3 A12 scanline filter.
//   a12_state_e : qualifier FSM states (LOW, ARMED, HIGH)
//   DEF_*       : default values for the filter parameters
package mmc3_pkg;

  typedef enum logic [1:0] {
    LOW   = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2
  } a12_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_LOW_M2_RISES  = 3;
  localparam int DEF_GLITCH_CYCLES = 2;
  localparam int DEF_M2_TIMEOUT    = 255;

endpackage

// File: rtl/mmc3_a12_scanline_filter_sync.sv
// bit_synchronizer
// Multi-flop synchronizer bringing an asynchronous input into the clk_i domain.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears every stage
//   d_i    : asynchronous input
//   q_o    : synchronized output (last stage)
module bit_synchronizer
  import mmc3_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mmc3_a12_scanline_filter.sv
// mmc3_a12_scanline_filter
// Clocked qualifier for PPU A12 rises feeding the MMC3 scanline IRQ counter.
// Only an A12 rise that follows A12 staying low for LOW_M2_RISES M2 rises
// produces a one-clock scanline_tick_o; sprite-fetch style short pulses do not.
// Optional glitch filter on the synchronized A12: macro MMC3_A12_GLITCH_FILTER_EN.
// Ports:
//   clk_i           : board clock, at least 4x the M2 frequency
//   rst_ni          : asynchronous active-low reset
//   m2_i            : CPU M2, asynchronous
//   ppu_a12_i       : PPU address bit 12, asynchronous
//   scanline_tick_o : one-clock pulse per qualified A12 rise
//   a12_filtered_o  : synchronized (and optionally glitch-filtered) A12 level
//   armed_o         : high while the FSM is ARMED
//   m2_active_o     : M2 has risen within the last M2_TIMEOUT clocks
module mmc3_a12_scanline_filter
  import mmc3_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int LOW_M2_RISES  = DEF_LOW_M2_RISES,
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
  parameter int M2_TIMEOUT    = DEF_M2_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic m2_i,
  input  logic ppu_a12_i,
  output logic scanline_tick_o,
  output logic a12_filtered_o,
  output logic armed_o,
  output logic m2_active_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (LOW_M2_RISES < 1 || LOW_M2_RISES > 15) begin : g_bad_low
    $error("LOW_M2_RISES must be in 1..15");
  end
  if (GLITCH_CYCLES < 1) begin : g_bad_glitch
    $error("GLITCH_CYCLES must be at least 1");
  end
  if (M2_TIMEOUT < 1 || M2_TIMEOUT > 65535) begin : g_bad_timeout
    $error("M2_TIMEOUT must be in 1..65535");
  end

  localparam logic [3:0]  LowTarget = 4'(LOW_M2_RISES);
  localparam logic [15:0] IdleMax   = 16'(M2_TIMEOUT);

  logic m2_s, a12_s, a12_f;
  logic m2_d_q, a12_f_d_q;
  logic m2_rise, a12_rise;

  a12_state_e  state_q, state_d;
  logic [3:0]  low_cnt_q, low_cnt_d;
  logic [15:0] idle_q, idle_d;
  logic        m2_active_q, m2_active_d;
  logic        tick_pend_q, tick_pend_d;
  logic        tick_q;

  bit_synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_m2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (m2_i),
    .q_o    (m2_s)
  );

  bit_synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_a12 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ppu_a12_i),
    .q_o    (a12_s)
  );

`ifdef MMC3_A12_GLITCH_FILTER_EN
  localparam int GlitchW = $clog2(GLITCH_CYCLES + 1);

  logic [GlitchW-1:0] glitch_cnt_q, glitch_cnt_d;
  logic               a12_f_q, a12_f_d;

  // The filtered level follows a12_s only after GLITCH_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    a12_f_d      = a12_f_q;
    glitch_cnt_d = '0;
    if (a12_s != a12_f_q) begin
      if (glitch_cnt_q == GlitchW'(GLITCH_CYCLES - 1)) begin
        a12_f_d = a12_s;
      end else begin
        glitch_cnt_d = glitch_cnt_q + GlitchW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a12_f_q      <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      a12_f_q      <= a12_f_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign a12_f = a12_f_q;
`else
  assign a12_f = a12_s;
`endif

  assign m2_rise  = m2_s & ~m2_d_q;
  assign a12_rise = a12_f & ~a12_f_d_q;

  // M2 idle watchdog: a stalled CPU clock suppresses ticks without
  // disturbing the FSM, so arming survives short stalls.
  always_comb begin
    idle_d      = idle_q;
    m2_active_d = m2_active_q;
    if (m2_rise) begin
      idle_d      = '0;
      m2_active_d = 1'b1;
    end else if (idle_q != IdleMax) begin
      idle_d = idle_q + 16'd1;
      if (idle_q + 16'd1 == IdleMax) begin
        m2_active_d = 1'b0;
      end
    end
  end

  // A12 level takes priority over a coincident M2 rise in LOW, so a rise
  // that lands with an M2 edge is never mistaken for extra low time.
  always_comb begin
    state_d     = state_q;
    low_cnt_d   = low_cnt_q;
    tick_pend_d = 1'b0;
    unique case (state_q)
      LOW: begin
        if (a12_f) begin
          state_d   = HIGH;
          low_cnt_d = '0;
        end else if (m2_rise && low_cnt_q != LowTarget) begin
          low_cnt_d = low_cnt_q + 4'd1;
          if (low_cnt_q + 4'd1 == LowTarget) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (a12_rise) begin
          state_d     = HIGH;
          low_cnt_d   = '0;
          tick_pend_d = m2_active_q;
        end
      end
      HIGH: begin
        low_cnt_d = '0;
        if (!a12_f) begin
          state_d = LOW;
        end
      end
      default: begin
        state_d   = LOW;
        low_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m2_d_q      <= 1'b0;
      a12_f_d_q   <= 1'b0;
      state_q     <= LOW;
      low_cnt_q   <= '0;
      idle_q      <= '0;
      m2_active_q <= 1'b0;
      tick_pend_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      m2_d_q      <= m2_s;
      a12_f_d_q   <= a12_f;
      state_q     <= state_d;
      low_cnt_q   <= low_cnt_d;
      idle_q      <= idle_d;
      m2_active_q <= m2_active_d;
      tick_pend_q <= tick_pend_d;
      tick_q      <= tick_pend_q;
    end
  end

  assign scanline_tick_o = tick_q;
  assign a12_filtered_o  = a12_f;
  assign armed_o         = (state_q == ARMED);
  assign m2_active_o     = m2_active_q;

endmodule

// File: tb/tb_mmc3_a12_scanline_filter.sv
// tb_mmc3_a12_scanline_filter
// Directed self-checking bench for mmc3_a12_scanline_filter (default parameters).
// Honours MMC3_A12_GLITCH_FILTER_EN for latency and glitch expectations.
module tb_mmc3_a12_scanline_filter;

`ifdef MMC3_A12_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic m2;
  logic a12;
  logic scanline_tick_o, a12_filtered_o, armed_o, m2_active_o;

  int testsRun    = 0;
  int testsFailed = 0;
  int tickCount   = 0;
  int backToBack  = 0;
  logic prevTick  = 1'b0;

  mmc3_a12_scanline_filter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .m2_i            (m2),
    .ppu_a12_i       (a12),
    .scanline_tick_o (scanline_tick_o),
    .a12_filtered_o  (a12_filtered_o),
    .armed_o         (armed_o),
    .m2_active_o     (m2_active_o)
  );

  always #5 clk = ~clk;

  // Counts ticks and flags any tick held for two consecutive clocks.
  always @(posedge clk) begin
    if (scanline_tick_o === 1'b1) tickCount++;
    if (scanline_tick_o === 1'b1 && prevTick === 1'b1) backToBack++;
    prevTick = scanline_tick_o;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One M2 period: 4 clocks high, 4 clocks low.
  task automatic m2Cycle();
    m2 = 1'b1;
    waitClk(4);
    m2 = 1'b0;
    waitClk(4);
  endtask

  // Drop A12, let it settle, then give three M2 rises so the FSM arms.
  task automatic armSequence();
    a12 = 1'b0;
    waitClk(6);
    repeat (3) m2Cycle();
    waitClk(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m2    = 1'b0;
    a12   = 1'b1;
    waitClk(4);
    testsRun++;
    if (scanline_tick_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_tick: got %b expected 0", scanline_tick_o); end
    testsRun++;
    if (a12_filtered_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_a12_filtered: got %b expected 0", a12_filtered_o); end
    testsRun++;
    if (armed_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_armed: got %b expected 0", armed_o); end
    testsRun++;
    if (m2_active_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_m2_active: got %b expected 0", m2_active_o); end
    a12 = 1'b0;
    waitClk(2);
    rst_n = 1'b1;
    waitClk(2);
  endtask

  task automatic test_qualified_rise();
    int t0;
    armSequence();
    testsRun++;
    if (armed_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL armed_after_3_rises: got %b expected 1", armed_o); end
    testsRun++;
    if (m2_active_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL m2_active_toggling: got %b expected 1", m2_active_o); end
    t0 = tickCount;
    a12 = 1'b1;
    waitClk(LAT - 1);
    testsRun++;
    if (scanline_tick_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL tick_early: got %b expected 0", scanline_tick_o); end
    waitClk(1);
    testsRun++;
    if (scanline_tick_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL tick_latency: got %b expected 1", scanline_tick_o); end
    waitClk(1);
    testsRun++;
    if (scanline_tick_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL tick_width: got %b expected 0", scanline_tick_o); end
    waitClk(4);
    testsRun++;
    if (tickCount - t0 !== 1) begin testsFailed++; $display("[TB] FAIL qualified_tick_count: got %0d expected 1", tickCount - t0); end
    testsRun++;
    if (armed_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL armed_drops: got %b expected 0", armed_o); end
    testsRun++;
    if (a12_filtered_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL a12_filtered_high: got %b expected 1", a12_filtered_o); end
  endtask

  task automatic test_short_low();
    int t0;
    a12 = 1'b0;
    waitClk(6);
    repeat (2) m2Cycle();
    waitClk(2);
    testsRun++;
    if (armed_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL short_low_not_armed: got %b expected 0", armed_o); end
    t0 = tickCount;
    a12 = 1'b1;
    waitClk(10);
    testsRun++;
    if (tickCount - t0 !== 0) begin testsFailed++; $display("[TB] FAIL short_low_no_tick: got %0d expected 0", tickCount - t0); end
    testsRun++;
    if (armed_o !== 1'b0 || a12_filtered_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL short_low_state_high: got armed=%b a12f=%b expected armed=0 a12f=1", armed_o, a12_filtered_o);
    end
  endtask

  task automatic test_sprite_lines();
    int t0;
    for (int line = 0; line < 2; line++) begin
      t0 = tickCount;
      armSequence();
      a12 = 1'b1;
      waitClk(4);
      for (int p = 0; p < 8; p++) begin
        a12 = 1'b0;
        m2Cycle();
        a12 = 1'b1;
        waitClk(4);
      end
      waitClk(8);
      testsRun++;
      if (tickCount - t0 !== 1) begin testsFailed++; $display("[TB] FAIL sprite_line%0d_ticks: got %0d expected 1", line, tickCount - t0); end
    end
  endtask

  task automatic test_glitch();
    int t0;
    armSequence();
    t0 = tickCount;
    a12 = 1'b1;
    waitClk(1);
    a12 = 1'b0;
    waitClk(12);
`ifdef MMC3_A12_GLITCH_FILTER_EN
    testsRun++;
    if (tickCount - t0 !== 0) begin testsFailed++; $display("[TB] FAIL glitch_no_tick: got %0d expected 0", tickCount - t0); end
    testsRun++;
    if (armed_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL glitch_stays_armed: got %b expected 1", armed_o); end
`else
    testsRun++;
    if (tickCount - t0 !== 1) begin testsFailed++; $display("[TB] FAIL unfiltered_glitch_tick: got %0d expected 1", tickCount - t0); end
    testsRun++;
    if (armed_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL unfiltered_glitch_disarms: got %b expected 0", armed_o); end
`endif
  endtask

  task automatic test_m2_timeout();
    int t0;
    a12 = 1'b0;
    waitClk(6);
    repeat (2) m2Cycle();
    m2 = 1'b1;
    waitClk(4);
    m2 = 1'b0;
    waitClk(253);
    testsRun++;
    if (m2_active_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL m2_active_before_timeout: got %b expected 1", m2_active_o); end
    waitClk(1);
    testsRun++;
    if (m2_active_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL m2_active_at_timeout: got %b expected 0", m2_active_o); end
    testsRun++;
    if (armed_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL armed_during_stall: got %b expected 1", armed_o); end
    t0 = tickCount;
    a12 = 1'b1;
    waitClk(10);
    testsRun++;
    if (tickCount - t0 !== 0) begin testsFailed++; $display("[TB] FAIL stalled_no_tick: got %0d expected 0", tickCount - t0); end
    testsRun++;
    if (armed_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL stalled_fsm_runs: got %b expected 0", armed_o); end
  endtask

  task automatic test_reset_mid();
    int t0;
    armSequence();
    testsRun++;
    if (armed_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL rearm_before_reset: got %b expected 1", armed_o); end
    t0 = tickCount;
    a12 = 1'b1;
    waitClk(LAT - 1);
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({scanline_tick_o, a12_filtered_o, armed_o, m2_active_o} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: got %b%b%b%b expected 0000", scanline_tick_o, a12_filtered_o, armed_o, m2_active_o);
    end
    waitClk(3);
    testsRun++;
    if (tickCount - t0 !== 0) begin testsFailed++; $display("[TB] FAIL midreset_pending_dropped: got %0d expected 0", tickCount - t0); end
    rst_n = 1'b1;
    waitClk(6);
    a12 = 1'b0;
    waitClk(6);
    m2Cycle();
    waitClk(2);
    t0 = tickCount;
    a12 = 1'b1;
    waitClk(10);
    testsRun++;
    if (tickCount - t0 !== 0) begin testsFailed++; $display("[TB] FAIL post_reset_first_rise: got %0d expected 0", tickCount - t0); end
    armSequence();
    t0 = tickCount;
    a12 = 1'b1;
    waitClk(10);
    testsRun++;
    if (tickCount - t0 !== 1) begin testsFailed++; $display("[TB] FAIL post_reset_qualified: got %0d expected 1", tickCount - t0); end
  endtask

  task automatic test_back_to_back();
    testsRun++;
    if (backToBack !== 0) begin testsFailed++; $display("[TB] FAIL back_to_back_ticks: got %0d expected 0", backToBack); end
  endtask

  initial begin
    rst_n = 1'b0;
    m2    = 1'b0;
    a12   = 1'b0;
    test_reset();
    test_qualified_rise();
    test_short_low();
    test_sprite_lines();
    test_glitch();
    test_m2_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
